// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the dictionary SPRAM arbiter.
package mem_arb_pkg;

  localparam int DEF_ASZ  = 17;
  localparam int DEF_DSZ  = 8;
  localparam int NREQ_MAX = 8;

  typedef enum logic {ARB_IDLE, ARB_GNT} arb_st;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } rr_res_t;

  // First set bit of req in the order ptr, ptr+1, ... modulo n.
  function automatic rr_res_t rr_next(input logic [NREQ_MAX-1:0] req,
                                      input logic [2:0] ptr, input int n);
    rr_res_t res;
    int      j;
    res = '0;
    for (int k = 0; k < NREQ_MAX; k++) begin
      j = (int'(ptr) + k) % n;
      if (k < n && !res.hit && req[j]) begin
        res.hit = 1'b1;
        res.idx = 3'(j);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational rotating-priority encoder.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 3,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx,
  output logic            hit
);

  rr_res_t res;

  always_comb begin
    res = rr_next(NREQ_MAX'(req), 3'(ptr), NREQ);
    idx = IW'(res.idx);
    hit = res.hit;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin owner-locking arbiter for the shared dictionary SPRAM port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int ASZ  = DEF_ASZ,
  parameter int DSZ  = DEF_DSZ,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     we,
  input  logic [NREQ*ASZ-1:0] ai,
  input  logic [NREQ*DSZ-1:0] vi,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     rvld,
  output logic [DSZ-1:0]      vo,
  output logic                bus_we,
  output logic [ASZ-1:0]      bus_ai,
  output logic [DSZ-1:0]      bus_vi,
  input  logic [DSZ-1:0]      bus_vo,
  output arb_st               st
);

  arb_st           st_q, st_d;
  logic [IW-1:0]   own_q, own_d, ptr_q, ptr_d, rtag_q;
  logic            rpend_q;
  logic [ASZ-1:0]  ai_q, own_ai;
  logic [DSZ-1:0]  vi_q, own_vi;
  logic [IW-1:0]   pick_idx, pick_nxt;
  logic            pick_hit, access;

  rr_picker #(.NREQ(NREQ)) u_pick (
    .req(req),
    .ptr(ptr_q),
    .idx(pick_idx),
    .hit(pick_hit)
  );

  assign pick_nxt = (pick_idx == IW'(NREQ-1)) ? '0 : pick_idx + 1'b1;

  // The owner's req is low whenever we search in ARB_GNT, so the picker
  // never re-selects it and the rotated ptr already ranks it last.
  always_comb begin
    st_d  = st_q;
    own_d = own_q;
    ptr_d = ptr_q;
    case (st_q)
      ARB_IDLE: if (pick_hit) begin
        st_d  = ARB_GNT;
        own_d = pick_idx;
        ptr_d = pick_nxt;
      end
      ARB_GNT: if (!req[own_q]) begin
        if (pick_hit) begin
          own_d = pick_idx;
          ptr_d = pick_nxt;
        end else begin
          st_d = ARB_IDLE;
        end
      end
      default: st_d = ARB_IDLE;
    endcase
  end

  assign access = (st_q == ARB_GNT) & req[own_q];
  assign own_ai = ai[own_q*ASZ +: ASZ];
  assign own_vi = vi[own_q*DSZ +: DSZ];

  assign bus_we = access & we[own_q];
  assign bus_ai = access ? own_ai : ai_q;
  assign bus_vi = access ? own_vi : vi_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= ARB_IDLE;
      own_q   <= '0;
      ptr_q   <= '0;
      rtag_q  <= '0;
      rpend_q <= 1'b0;
      ai_q    <= '0;
      vi_q    <= '0;
    end else begin
      st_q    <= st_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      rpend_q <= access & ~we[own_q];
      if (access) begin
        rtag_q <= own_q;
        ai_q   <= own_ai;
        vi_q   <= own_vi;
      end
    end
  end

  assign gnt  = (st_q == ARB_GNT) ? (NREQ'(1) << own_q) : '0;
  assign rvld = rpend_q ? (NREQ'(1) << rtag_q) : '0;
  assign vo   = bus_vo;
  assign st   = st_q;

endmodule
